// File: rtl/car_motion_pkg.sv
// Shared constants and helpers for the road-lane car motion logic and the
// sprite display stage that consumes its positions.
package car_motion_pkg;

    localparam int unsigned H_VISIBLE_AREA = 640;
    localparam int unsigned V_VISIBLE_AREA = 480;
    localparam int unsigned TILE_SIZE      = 32;
    localparam int unsigned NUM_LANES      = 5;

    localparam int unsigned C_LINE_1_Y = 96;
    localparam int unsigned C_LINE_2_Y = 160;
    localparam int unsigned C_LINE_3_Y = 224;
    localparam int unsigned C_LINE_4_Y = 288;
    localparam int unsigned C_LINE_5_Y = 352;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] period_t;

    // Lane move period after the difficulty level is applied.
    // A base of zero is read as one; the result saturates at one.
    function automatic period_t effective_period(input period_t base, input logic [2:0] level);
        period_t base_fixed;
        period_t result;
        base_fixed = (base == 4'd0) ? 4'd1 : base;
        if (base_fixed > {1'b0, level}) begin
            result = base_fixed - {1'b0, level};
        end else begin
            result = 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/car_motion_controller_car_lane.sv
// One road lane: a frame divider that paces the car, plus the car's X
// position register with wrap-around at the visible screen width.
module car_lane
    import car_motion_pkg::*;
#(
    parameter period_t     PERIOD         = 4'd4,
    parameter coord_t      INIT_X         = 10'd0,
    parameter int unsigned STEP           = 2,
    parameter int unsigned H_VISIBLE_AREA = 640
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Tick,
    input  logic       i_Pause,
    input  logic [2:0] i_Level,
    input  logic       i_Reverse,
    output logic [9:0] o_X
);

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] H_W    = 11'(H_VISIBLE_AREA);

    logic [3:0]  count_r;
    coord_t      x_r;
    period_t     period_s;
    logic [4:0]  count_inc_s;
    logic        move_s;
    logic        advance_s;
    logic [10:0] x_wide_s;
    logic [10:0] sum_s;
    logic [10:0] next_wide_s;
    coord_t      next_x_s;

    // Divider compare and wrap-aware next position; 11-bit math avoids overflow.
    always_comb begin
        period_s    = effective_period(PERIOD, i_Level);
        count_inc_s = {1'b0, count_r} + 5'd1;
        move_s      = (count_inc_s >= {1'b0, period_s});
        advance_s   = i_Tick && !i_Pause;
        x_wide_s    = {1'b0, x_r};
        sum_s       = x_wide_s + STEP_W;
        next_wide_s = x_wide_s;
        if (i_Reverse) begin
            if (x_wide_s < STEP_W) begin
                next_wide_s = x_wide_s + H_W - STEP_W;
            end else begin
                next_wide_s = x_wide_s - STEP_W;
            end
        end else begin
            if (sum_s >= H_W) begin
                next_wide_s = sum_s - H_W;
            end else begin
                next_wide_s = sum_s;
            end
        end
        next_x_s = next_wide_s[9:0];
    end

    // Divider and position state; a tick seen while paused is simply dropped.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count_r <= 4'd0;
            x_r     <= INIT_X;
        end else if (advance_s) begin
            if (move_s) begin
                count_r <= 4'd0;
                x_r     <= next_x_s;
            end else begin
                count_r <= count_inc_s[3:0];
                x_r     <= x_r;
            end
        end else begin
            count_r <= count_r;
            x_r     <= x_r;
        end
    end

    assign o_X = x_r;

endmodule

// File: rtl/car_motion_controller.sv
// Frame-paced horizontal motion for the five road-lane cars. Produces a
// one-cycle frame tick in vertical blanking and moves each lane on it.
module car_motion_controller
    import car_motion_pkg::*;
#(
    parameter int unsigned H_VISIBLE_AREA = car_motion_pkg::H_VISIBLE_AREA,
    parameter int unsigned V_VISIBLE_AREA = car_motion_pkg::V_VISIBLE_AREA,
    parameter int unsigned STEP           = 2,
    parameter logic [19:0] LANE_PERIOD    = 20'h43254,
    parameter logic [49:0] LANE_INIT_X    = {10'd512, 10'd384, 10'd256, 10'd128, 10'd0},
    parameter logic [3:0]  LANE_REVERSE   = 4'b1010
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_H_Counter,
    input  logic [9:0] i_V_Counter,
    input  logic [2:0] i_Level,
    input  logic       i_Pause,
    output logic [9:0] o_Car_1X_Position,
    output logic [9:0] o_Car_2X_Position,
    output logic [9:0] o_Car_3X_Position,
    output logic [9:0] o_Car_4X_Position,
    output logic [9:0] o_Car_5X_Position,
    output logic [3:0] o_Reverse,
    output logic       o_Frame_Tick
);

    localparam logic [9:0] TICK_LINE = 10'(V_VISIBLE_AREA);

    logic       tick_r;
    logic [3:0] reverse_r;
    coord_t     lane_x_s [NUM_LANES];

    // Frame tick: registered detection of the first pixel of the blanking line.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= (i_H_Counter == 10'd0) && (i_V_Counter == TICK_LINE);
        end
    end

    // Direction flags held in a register so per-level direction changes stay local.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            reverse_r <= LANE_REVERSE;
        end else begin
            reverse_r <= reverse_r;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        // Lane 5 shares its direction with lane 1.
        localparam int REV_BIT = (g == 4) ? 0 : g;

        car_lane #(
            .PERIOD        (LANE_PERIOD[4*g +: 4]),
            .INIT_X        (LANE_INIT_X[10*g +: 10]),
            .STEP          (STEP),
            .H_VISIBLE_AREA(H_VISIBLE_AREA)
        ) u_lane (
            .i_Clk    (i_Clk),
            .i_Reset  (i_Reset),
            .i_Tick   (tick_r),
            .i_Pause  (i_Pause),
            .i_Level  (i_Level),
            .i_Reverse(reverse_r[REV_BIT]),
            .o_X      (lane_x_s[g])
        );
    end

    assign o_Car_1X_Position = lane_x_s[0];
    assign o_Car_2X_Position = lane_x_s[1];
    assign o_Car_3X_Position = lane_x_s[2];
    assign o_Car_4X_Position = lane_x_s[3];
    assign o_Car_5X_Position = lane_x_s[4];
    assign o_Reverse         = reverse_r;
    assign o_Frame_Tick      = tick_r;

endmodule
